ce_pool_requant: RTL and testbench
==================================

// Module: ce_pool_requant
// PURPOSE
//  Downstream stage of the convolution engine. Consumes the wide raw accumulator stream (d_in/en_in) in raster order.
//  Each sample is requantized: arithmetic shift right with rounding, optional ReLU, saturation to N bits.
//  Optional 2x2/stride-2 max pooling through an internal half-row line buffer.
//  Feeds the next layer's data2conv window builder.
// PARAMETERS
//  N      8   output data width (signed two's complement)
//  M      8   CE weight width; sets input width IN_W = N+M+15
//  SR     2   right-shift amount before saturation (0..IN_W-N)
//  RELU   1   1: negative requantized values forced to 0; 0: signed output
//  POOL   1   1: 2x2 max pool; 0: bypass, one output per input
//  IMG_W  28  input feature-map columns (>=2 when POOL=1)
//  IMG_H  28  input feature-map rows (>=2 when POOL=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-low (rst==0 resets)
//  d_in       in   IN_W   raw CE result, signed, valid when en_in=1
//  en_in      in   1      input strobe; one pixel per high cycle; gaps allowed
//  d_out      out  N      requantized (pooled) pixel, signed
//  en_out     out  1      d_out valid strobe
//  row_end    out  1      pulses with en_out of last output of an output row
//  frame_end  out  1      pulses with en_out of last output of a frame
//  sat_flag   out  1      sticky; set when any requantized value saturated
// BEHAVIOUR
//  Reset: d_out=0, en_out=0, row_end=0, frame_end=0, sat_flag=0, col/row counters=0, pipeline valids=0.
//    Line buffer is not cleared.
//  Reset mid-frame: discard partial frame; next en_in beat is pixel (0,0).
//  Stage 1 (registered): q = (d_in + (SR>0 ? 1<<(SR-1) : 0)) >>> SR, computed at IN_W+1 bits, no wrap.
//    If RELU and q<0: q=0.
//    Then clip to [-2^(N-1), 2^(N-1)-1]; any clip sets sat_flag.
//  Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on en_in.
//    col wraps to 0 and increments row; row wraps to 0 at frame end. Back-to-back frames need no idle cycle.
//  POOL=0: every stage-1 value is registered to d_out.
//    en_out is high exactly 2 cycles after its en_in.
//    row_end at col=IMG_W-1; frame_end additionally at row=IMG_H-1.
//  POOL=1, per stage-1 value with its (col,row):
//   - even col: hold value in pair register h.
//   - odd col, even row: lbuf[col>>1] <= max(h, q).
//   - odd col, odd row: d_out <= max(lbuf[col>>1], h, q) (signed compare); en_out fires 2 cycles after that en_in.
//   - odd IMG_W: last column ignored. Odd IMG_H: last row ignored; counters still cover the full frame.
//   - row_end at output col IMG_W/2-1; frame_end on the last output of row IMG_H/2-1 (pooled coords).
//  Outputs are strobes: no backpressure; downstream must accept every en_out.
//  en_in during reset is ignored.
// STRUCTURE
//  Shared package cnn_pkg holds: EXT=15, IN_W(N,M)=N+M+EXT, sat bounds SAT_MAX=2^(N-1)-1, SAT_MIN=-(2^(N-1)).
//  Sub-module requant_sat (combinational shift/round/ReLU/clip + sat bit), instantiated once ahead of the stage-1 register.
//  Top holds counters, pair register, lbuf[IMG_W/2] x N flops, max tree, output register.
// TESTING (N=8, M=8, SR=2, RELU=1 unless stated)
//  1 POOL=0: d_in=100 -> 25; d_in=1000 -> 127 and sat_flag=1; d_in=-40 -> 0.
//    RELU=0: d_in=-40 -> -10; d_in=-1000 -> -128.
//  2 POOL=1, IMG_W=IMG_H=4, d_in=4*k for k=0..15 contiguous -> d_out 5,7,13,15.
//    Each output 2 cycles after pixel k=5,7,13,15; row_end on 7 and 15; frame_end on 15.
//  3 Same stream as 2 with en_in low every other cycle, plus a 10-cycle gap mid-row -> identical values and flags.
//  4 Same setup as 2: rst=0 after 6 pixels, then full frame -> only 5,7,13,15; no stray en_out; sat_flag=0.
//  5 IMG_W=IMG_H=5, d_in=4*k for k=0..24 -> 6,8,16,18; two frames back-to-back -> same 4 outputs twice.
//    frame_end on each 4th output.
//  6 POOL=1, window values {-3,-7,-1,-5}*4, RELU=0 -> -1 (signed max).

Source files
------------

// File: rtl/cnn_pkg.sv
// ============================================================================
// Module : cnn_pkg
// Brief  : Shared widths and saturation bounds for the convolution engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int EXT = 15;

  function automatic int in_w(input int n, input int m);
    return n + m + EXT;
  endfunction

  function automatic int sat_max(input int n);
    return (2 ** (n - 1)) - 1;
  endfunction

  function automatic int sat_min(input int n);
    return -(2 ** (n - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ce_pool_requant_if.sv
// ============================================================================
// Module : ce_pool_requant_if
// Brief  : Accumulator-in / pixel-out strobe bus of the requant/pool stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ce_pool_requant_if
  import cnn_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 8
);
  localparam int IN_W = in_w(N, M);

  logic [IN_W-1:0] d_in;
  logic            en_in;
  logic [N-1:0]    d_out;
  logic            en_out;
  logic            row_end;
  logic            frame_end;
  logic            sat_flag;

  modport master (
    output d_in, en_in,
    input  d_out, en_out, row_end, frame_end, sat_flag
  );

  modport slave (
    input  d_in, en_in,
    output d_out, en_out, row_end, frame_end, sat_flag
  );

endinterface

`default_nettype wire

// File: rtl/requant_sat.sv
// ============================================================================
// Module : requant_sat
// Brief  : Combinational round-shift, optional ReLU and clip to N signed bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module requant_sat
  import cnn_pkg::*;
#(
  parameter int N    = 8,
  parameter int IN_W = 31,
  parameter int SR   = 2,
  parameter bit RELU = 1'b1
) (
  input  wire logic signed [IN_W-1:0] d,
  output      logic signed [N-1:0]    q,
  output      logic                   sat
);

  // One guard bit keeps the rounding add from wrapping.
  localparam logic signed [IN_W:0] c_RND     = (IN_W+1)'((2 ** SR) / 2);
  localparam logic signed [IN_W:0] c_SAT_MAX = (IN_W+1)'(sat_max(N));
  localparam logic signed [IN_W:0] c_SAT_MIN = (IN_W+1)'(sat_min(N));

  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_shr;
  logic signed [IN_W:0] w_rel;

  always_comb begin
    w_sum = {d[IN_W-1], d} + c_RND;
    w_shr = w_sum >>> SR;
    w_rel = (RELU && (w_shr < 0)) ? '0 : w_shr;
    sat   = 1'b0;
    q     = w_rel[N-1:0];
    if (w_rel > c_SAT_MAX) begin
      q   = c_SAT_MAX[N-1:0];
      sat = 1'b1;
    end else if (w_rel < c_SAT_MIN) begin
      q   = c_SAT_MIN[N-1:0];
      sat = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ce_pool_requant.sv
// ============================================================================
// Module : ce_pool_requant
// Brief  : Requantize raster accumulator stream, optionally 2x2/stride-2 max pool.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ce_pool_requant
  import cnn_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int SR    = 2,
  parameter bit RELU  = 1'b1,
  parameter bit POOL  = 1'b1,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input wire logic         clk,
  input wire logic         rst,
  ce_pool_requant_if.slave bus
);

  localparam int IN_W = in_w(N, M);
  localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [c_CW-1:0]     r_col_cnt;
  logic [c_RW-1:0]     r_row_cnt;
  logic [c_CW-1:0]     r_col;
  logic [c_RW-1:0]     r_row;
  logic signed [N-1:0] r_q;
  logic                r_v;
  logic                r_sat_flag;
  logic signed [N-1:0] w_q;
  logic                w_sat;
  logic                w_last_col;
  logic                w_last_row;

  logic signed [N-1:0] r_d_out;
  logic                r_en_out;
  logic                r_row_end;
  logic                r_frame_end;

  requant_sat #(
    .N    (N),
    .IN_W (IN_W),
    .SR   (SR),
    .RELU (RELU)
  ) u_requant_sat (
    .d   (bus.d_in),
    .q   (w_q),
    .sat (w_sat)
  );

  assign w_last_col = (r_col_cnt == c_CW'(IMG_W - 1));
  assign w_last_row = (r_row_cnt == c_RW'(IMG_H - 1));

  // Stage 1: requantized value tagged with the raster position it came from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_q        <= '0;
      r_v        <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      r_v <= bus.en_in;
      if (bus.en_in) begin
        r_q        <= w_q;
        r_col      <= r_col_cnt;
        r_row      <= r_row_cnt;
        r_sat_flag <= r_sat_flag | w_sat;
        if (w_last_col) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
        end
      end
    end
  end

  if (POOL) begin : g_pool
    localparam int c_HW = IMG_W / 2;
    localparam int c_PW = (c_HW > 1) ? $clog2(c_HW) : 1;
    localparam logic [c_CW-1:0] c_LAST_PC = c_CW'(2 * c_HW - 1);
    localparam logic [c_RW-1:0] c_LAST_PR = c_RW'(2 * (IMG_H / 2) - 1);

    logic signed [N-1:0] r_h;
    logic signed [N-1:0] r_lbuf [c_HW];
    logic [c_PW-1:0]     w_pidx;
    logic signed [N-1:0] w_m1;
    logic signed [N-1:0] w_m2;
    logic                w_in_win;
    logic                w_last_pc;

    // Trailing odd column/row never form a complete window.
    assign w_in_win  = r_v && (r_col <= c_LAST_PC) && (r_row <= c_LAST_PR);
    assign w_last_pc = (r_col == c_LAST_PC);
    assign w_pidx    = c_PW'(r_col >> 1);
    assign w_m1      = (r_h > r_q) ? r_h : r_q;
    assign w_m2      = (r_lbuf[w_pidx] > w_m1) ? r_lbuf[w_pidx] : w_m1;

    always_ff @(posedge clk) begin
      if (w_in_win && r_col[0] && !r_row[0]) begin
        r_lbuf[w_pidx] <= w_m1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_h         <= '0;
        r_d_out     <= '0;
        r_en_out    <= 1'b0;
        r_row_end   <= 1'b0;
        r_frame_end <= 1'b0;
      end else begin
        r_en_out    <= 1'b0;
        r_row_end   <= 1'b0;
        r_frame_end <= 1'b0;
        if (w_in_win) begin
          if (!r_col[0]) begin
            r_h <= r_q;
          end else if (r_row[0]) begin
            r_d_out     <= w_m2;
            r_en_out    <= 1'b1;
            r_row_end   <= w_last_pc;
            r_frame_end <= w_last_pc && (r_row == c_LAST_PR);
          end
        end
      end
    end
  end else begin : g_bypass
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_d_out     <= '0;
        r_en_out    <= 1'b0;
        r_row_end   <= 1'b0;
        r_frame_end <= 1'b0;
      end else begin
        r_en_out    <= r_v;
        r_row_end   <= r_v && (r_col == c_CW'(IMG_W - 1));
        r_frame_end <= r_v && (r_col == c_CW'(IMG_W - 1)) && (r_row == c_RW'(IMG_H - 1));
        if (r_v) begin
          r_d_out <= r_q;
        end
      end
    end
  end

  assign bus.d_out     = r_d_out;
  assign bus.en_out    = r_en_out;
  assign bus.row_end   = r_row_end;
  assign bus.frame_end = r_frame_end;
  assign bus.sat_flag  = r_sat_flag;

endmodule

`default_nettype wire

// File: tb/tb_ce_pool_requant.sv
// ============================================================================
// Module : tb_ce_pool_requant
// Brief  : Directed checks of requantization, pooling, flags and reset behaviour.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ce_pool_requant;

  typedef struct {
    int               cyc;
    logic signed [7:0] d;
    logic             re;
    logic             fe;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [30:0] d_in = '0;
  logic        en_in = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  ev_t qa[$], qb[$], qc[$], qd[$], qe[$];
  int  st[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ce_pool_requant_if #(.N(8), .M(8)) bus_a ();
  ce_pool_requant_if #(.N(8), .M(8)) bus_b ();
  ce_pool_requant_if #(.N(8), .M(8)) bus_c ();
  ce_pool_requant_if #(.N(8), .M(8)) bus_d ();
  ce_pool_requant_if #(.N(8), .M(8)) bus_e ();

  assign bus_a.d_in = d_in;  assign bus_a.en_in = en_in;
  assign bus_b.d_in = d_in;  assign bus_b.en_in = en_in;
  assign bus_c.d_in = d_in;  assign bus_c.en_in = en_in;
  assign bus_d.d_in = d_in;  assign bus_d.en_in = en_in;
  assign bus_e.d_in = d_in;  assign bus_e.en_in = en_in;

  ce_pool_requant #(.N(8), .M(8), .SR(2), .RELU(1'b1), .POOL(1'b0), .IMG_W(4), .IMG_H(2))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  ce_pool_requant #(.N(8), .M(8), .SR(2), .RELU(1'b0), .POOL(1'b0), .IMG_W(4), .IMG_H(2))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  ce_pool_requant #(.N(8), .M(8), .SR(2), .RELU(1'b1), .POOL(1'b1), .IMG_W(4), .IMG_H(4))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));
  ce_pool_requant #(.N(8), .M(8), .SR(2), .RELU(1'b1), .POOL(1'b1), .IMG_W(5), .IMG_H(5))
    u_d (.clk(clk), .rst(rst), .bus(bus_d));
  ce_pool_requant #(.N(8), .M(8), .SR(2), .RELU(1'b0), .POOL(1'b1), .IMG_W(2), .IMG_H(2))
    u_e (.clk(clk), .rst(rst), .bus(bus_e));

  function automatic ev_t mk_ev(input logic [7:0] d, input logic re, input logic fe);
    ev_t e;
    e.cyc = cyc;
    e.d   = d;
    e.re  = re;
    e.fe  = fe;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus_a.en_out) qa.push_back(mk_ev(bus_a.d_out, bus_a.row_end, bus_a.frame_end));
    if (bus_b.en_out) qb.push_back(mk_ev(bus_b.d_out, bus_b.row_end, bus_b.frame_end));
    if (bus_c.en_out) qc.push_back(mk_ev(bus_c.d_out, bus_c.row_end, bus_c.frame_end));
    if (bus_d.en_out) qd.push_back(mk_ev(bus_d.d_out, bus_d.row_end, bus_d.frame_end));
    if (bus_e.en_out) qe.push_back(mk_ev(bus_e.d_out, bus_e.row_end, bus_e.frame_end));
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_ev(input string tag, input ev_t q[$], input int idx,
                          input int d, input int re, input int fe, input int pix);
    if (idx >= q.size()) begin
      check_val({tag, "_present"}, q.size(), idx + 1);
    end else begin
      check_val({tag, "_d"},   q[idx].d,   d);
      check_val({tag, "_re"},  q[idx].re,  re);
      check_val({tag, "_fe"},  q[idx].fe,  fe);
      check_val({tag, "_cyc"}, q[idx].cyc, st[pix] + 2);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset(input bit clr_q);
    rst   = 1'b0;
    en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    st.delete();
    if (clr_q) begin
      qa.delete(); qb.delete(); qc.delete(); qd.delete(); qe.delete();
    end
  endtask

  task automatic send(input int v);
    d_in  = 31'(v);
    en_in = 1'b1;
    st.push_back(cyc);
    @(posedge clk);
    #1;
    en_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pool4(input string tag);
    check_val({tag, "_count"}, qc.size(), 4);
    check_ev({tag, "_o0"}, qc, 0, 5,  0, 0, 5);
    check_ev({tag, "_o1"}, qc, 1, 7,  1, 0, 7);
    check_ev({tag, "_o2"}, qc, 2, 13, 0, 0, 13);
    check_ev({tag, "_o3"}, qc, 3, 15, 1, 1, 15);
    check_val({tag, "_sat"}, bus_c.sat_flag, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #3;
    check_val("rst_d_out",   bus_a.d_out,     0);
    check_val("rst_en_out",  bus_c.en_out,    0);
    check_val("rst_row_end", bus_a.row_end,   0);
    check_val("rst_frm_end", bus_c.frame_end, 0);
    check_val("rst_sat",     bus_b.sat_flag,  0);
    @(posedge clk);
    #1;
    do_reset(1'b1);

    // Bypass requantization, saturation, ReLU and row/frame flags
    send(100);
    idle(4);
    check_val("t1_sat_early", bus_a.sat_flag, 0);
    send(1000); send(-40); send(-1000);
    for (int i = 0; i < 4; i++) send(100);
    idle(4);
    check_val("t1a_count", qa.size(), 8);
    check_ev("t1a_100",   qa, 0, 25,  0, 0, 0);
    check_ev("t1a_1000",  qa, 1, 127, 0, 0, 1);
    check_ev("t1a_m40",   qa, 2, 0,   0, 0, 2);
    check_ev("t1a_m1000", qa, 3, 0,   1, 0, 3);
    check_ev("t1a_last",  qa, 7, 25,  1, 1, 7);
    check_val("t1a_sat", bus_a.sat_flag, 1);
    check_ev("t1b_m40",   qb, 2, -10,  0, 0, 2);
    check_ev("t1b_m1000", qb, 3, -128, 1, 0, 3);
    check_val("t1b_sat", bus_b.sat_flag, 1);

    // Contiguous 4x4 pooled frame
    do_reset(1'b1);
    check_val("t2_sat_cleared", bus_a.sat_flag, 0);
    for (int k = 0; k < 16; k++) send(4 * k);
    idle(4);
    check_pool4("t2");

    // Same frame with alternate-cycle gaps and a long mid-row stall
    do_reset(1'b1);
    for (int k = 0; k < 16; k++) begin
      send(4 * k);
      idle(1);
      if (k == 9) idle(10);
    end
    idle(4);
    check_pool4("t3");

    // Reset in mid-frame discards the partial frame
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) send(4 * k);
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) send(4 * k);
    idle(4);
    check_pool4("t4");

    // Odd 5x5 geometry, two frames back to back
    do_reset(1'b1);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 25; k++) send(4 * k);
    idle(4);
    check_val("t5_count", qd.size(), 8);
    check_ev("t5_f0o0", qd, 0, 6,  0, 0, 6);
    check_ev("t5_f0o1", qd, 1, 8,  1, 0, 8);
    check_ev("t5_f0o2", qd, 2, 16, 0, 0, 16);
    check_ev("t5_f0o3", qd, 3, 18, 1, 1, 18);
    check_ev("t5_f1o0", qd, 4, 6,  0, 0, 31);
    check_ev("t5_f1o1", qd, 5, 8,  1, 0, 33);
    check_ev("t5_f1o2", qd, 6, 16, 0, 0, 41);
    check_ev("t5_f1o3", qd, 7, 18, 1, 1, 43);

    // Signed max over an all-negative window
    do_reset(1'b1);
    send(-12); send(-28); send(-4); send(-20);
    idle(4);
    check_val("t6_count", qe.size(), 1);
    check_ev("t6_max", qe, 0, -1, 1, 1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
